credit_retry_buffer: RTL and testbench

Parametrised credit/retry ingress buffer between an RX requester port and a TX egress port. It generalises the fixed 4-entry credit-and-deadlock block: data depth, ID and payload widths, stall threshold and credit-queue depth are all parameters. It also adds exact reservation arithmetic, a credit-queue-full backoff, a spurious-credit error flag and occupancy status outputs. A requester that stalls too long on a full buffer is told to retry; it later receives a credit that guarantees it a slot.

---
 rtl/credit_retry_buffer.sv | 184 ++++++++++++++++++
 tb/tb_credit_retry_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_retry_buffer.sv
// Purpose: credit/retry ingress buffer with a data FIFO feeding a 2-entry egress skid buffer.
// Latency: an accepted beat reaches tx_* two cycles later through an idle pipeline; one beat per cycle sustained.
// Backpressure: rx_ready_o drops when all slots are occupied or reserved; long stalls get retry plus a later credit.

module sync_fifo #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  mem [N];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  // Entry storage; no reset needed because count gates every consumer of head_dat.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; a push while full is legal only alongside a pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module credit_retry_buffer #(
  parameter int DEPTH        = 4,
  parameter int ID_W         = 3,
  parameter int PAYLOAD_W    = 5,
  parameter int STALL_THRESH = 2,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              rx_valid_i,
  input  logic [ID_W-1:0]                   rx_id_i,
  input  logic [PAYLOAD_W-1:0]              rx_payload_i,
  input  logic                              rx_credit_i,
  output logic                              rx_ready_o,
  output logic                              rx_retry_o,
  output logic                              tx_valid_o,
  output logic [ID_W-1:0]                   tx_id_o,
  output logic [PAYLOAD_W-1:0]              tx_payload_o,
  input  logic                              tx_ready_i,
  output logic                              credit_gnt_o,
  output logic [ID_W-1:0]                   credit_id_o,
  output logic [$clog2(DEPTH+1)-1:0]        rsv_cnt_o,
  output logic [$clog2(CREDIT_DEPTH+1)-1:0] credits_pending_o,
  output logic                              cred_err_o
);
  localparam int RSV_W = $clog2(DEPTH + 1);
  localparam int CP_W  = $clog2(CREDIT_DEPTH + 1);
  localparam int CNT_W = $clog2(STALL_THRESH + 1);
  localparam logic [RSV_W-1:0] RSV_FULL = RSV_W'(DEPTH);
  localparam logic [CP_W-1:0]  CP_FULL  = CP_W'(CREDIT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STALL_THRESH);

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [PAYLOAD_W-1:0] payload;
  } beat_t;

  logic [RSV_W-1:0] rsv_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [RSV_W-1:0] data_cnt;
  logic [RSV_W-1:0] res;
  beat_t            data_head;
  beat_t            rx_beat;
  logic [CP_W-1:0]  cred_cnt;
  logic [ID_W-1:0]  cred_head;
  beat_t            skid0_q, skid1_q, skid0_d, skid1_d;
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic             credited, push, pop, deq, stalled;

  // Reserved slots are those counted in rsv but not yet holding data.
  assign res        = rsv_q - data_cnt;
  assign credited   = rx_credit_i & (res != '0);
  assign rx_ready_o = credited | (rsv_q != RSV_FULL);
  assign push       = rx_valid_i & rx_ready_o;
  // A full skid buffer still accepts when its head leaves this cycle.
  assign pop        = (data_cnt != '0) & ((skid_cnt_q != 2'd2) | tx_ready_i);
  assign deq        = tx_valid_o & tx_ready_i;
  assign stalled    = rx_valid_i & ~credited & (rsv_q == RSV_FULL);
  assign rx_retry_o = stalled & (cnt_q == CNT_SAT) & (cred_cnt != CP_FULL);

  // Every pop frees a slot; if someone is owed a credit, the slot goes to them.
  assign credit_gnt_o = pop & (cred_cnt != '0);
  assign credit_id_o  = credit_gnt_o ? cred_head : '0;

  assign tx_valid_o        = (skid_cnt_q != 2'd0);
  assign tx_id_o           = tx_valid_o ? skid0_q.id : '0;
  assign tx_payload_o      = tx_valid_o ? skid0_q.payload : '0;
  assign rsv_cnt_o         = rsv_q;
  assign credits_pending_o = cred_cnt;
  assign cred_err_o        = err_q;
  assign rx_beat           = '{id: rx_id_i, payload: rx_payload_i};

  sync_fifo #(.W($bits(beat_t)), .N(DEPTH), .CW(RSV_W)) u_data_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (rx_beat),
    .pop      (pop),
    .head_dat (data_head),
    .count    (data_cnt)
  );

  sync_fifo #(.W(ID_W), .N(CREDIT_DEPTH), .CW(CP_W)) u_credit_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (rx_retry_o),
    .push_dat (rx_id_i),
    .pop      (credit_gnt_o),
    .head_dat (cred_head),
    .count    (cred_cnt)
  );

  // Skid next state: shift out the head on handshake, then append the popped beat.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    if (deq) begin
      skid0_d    = skid1_q;
      skid_cnt_d = skid_cnt_q - 2'd1;
    end
    if (pop) begin
      if (skid_cnt_d == 2'd0) skid0_d = data_head;
      else                    skid1_d = data_head;
      skid_cnt_d = skid_cnt_d + 2'd1;
    end
  end

  // Skid buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid0_q    <= '0;
      skid1_q    <= '0;
      skid_cnt_q <= '0;
    end else begin
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  // Reservation count, stall counter and sticky spurious-credit flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsv_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      rsv_q <= rsv_q + RSV_W'(push & ~credited) + RSV_W'(credit_gnt_o) - RSV_W'(pop);
      if (pop)                              cnt_q <= '0;
      else if (stalled && cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
      if (rx_valid_i && rx_credit_i && res == '0) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_credit_retry_buffer.sv
// Bench for credit_retry_buffer: directed scenarios with literal checks plus a queue-level reference model.
// The model is compared against every output on each falling clock edge.
// Inputs change 1 time unit after the rising edge; literal checks sample 2 units later.

module tb_credit_retry_buffer;
  localparam int DEPTH = 4;
  localparam int ID_W = 3;
  localparam int PAYLOAD_W = 5;
  localparam int STALL = 2;
  localparam int CDEPTH = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 rx_valid_i = 1'b0;
  logic [ID_W-1:0]      rx_id_i = '0;
  logic [PAYLOAD_W-1:0] rx_payload_i = '0;
  logic                 rx_credit_i = 1'b0;
  logic                 rx_ready_o, rx_retry_o, tx_valid_o, credit_gnt_o, cred_err_o;
  logic [ID_W-1:0]      tx_id_o, credit_id_o;
  logic [PAYLOAD_W-1:0] tx_payload_o;
  logic                 tx_ready_i = 1'b0;
  logic [2:0]           rsv_cnt_o;
  logic [2:0]           credits_pending_o;

  int n_cmp = 0;
  int n_fail = 0;

  credit_retry_buffer #(
    .DEPTH(DEPTH), .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W),
    .STALL_THRESH(STALL), .CREDIT_DEPTH(CDEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid_i(rx_valid_i), .rx_id_i(rx_id_i), .rx_payload_i(rx_payload_i),
    .rx_credit_i(rx_credit_i), .rx_ready_o(rx_ready_o), .rx_retry_o(rx_retry_o),
    .tx_valid_o(tx_valid_o), .tx_id_o(tx_id_o), .tx_payload_o(tx_payload_o),
    .tx_ready_i(tx_ready_i), .credit_gnt_o(credit_gnt_o), .credit_id_o(credit_id_o),
    .rsv_cnt_o(rsv_cnt_o), .credits_pending_o(credits_pending_o), .cred_err_o(cred_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_data[$];
  logic [7:0] m_skid[$];
  int         m_cred[$];
  int m_rsv = 0, m_cnt = 0, m_err = 0;
  int m_res, e_id, e_pl, e_gid;
  bit m_credited, e_ready, m_pop, e_gnt, m_stalled, e_retry, e_txv, m_push;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_data.delete(); m_skid.delete(); m_cred.delete();
        m_rsv = 0; m_cnt = 0; m_err = 0;
      end
      m_res      = m_rsv - int'(m_data.size());
      m_credited = rx_credit_i && (m_res > 0);
      e_ready    = m_credited || (m_rsv < DEPTH);
      m_pop      = (m_data.size() > 0) && ((m_skid.size() < 2) || tx_ready_i);
      e_gnt      = m_pop && (m_cred.size() > 0);
      e_gid      = e_gnt ? m_cred[0] : 0;
      m_stalled  = rx_valid_i && !m_credited && (m_rsv == DEPTH);
      e_retry    = m_stalled && (m_cnt == STALL) && (m_cred.size() < CDEPTH);
      e_txv      = m_skid.size() > 0;
      e_id       = e_txv ? int'(m_skid[0][7:5]) : 0;
      e_pl       = e_txv ? int'(m_skid[0][4:0]) : 0;
      chk("m_rx_ready", 32'(rx_ready_o), 32'(e_ready));
      chk("m_rx_retry", 32'(rx_retry_o), 32'(e_retry));
      chk("m_tx_valid", 32'(tx_valid_o), 32'(e_txv));
      chk("m_tx_id", 32'(tx_id_o), e_id);
      chk("m_tx_payload", 32'(tx_payload_o), e_pl);
      chk("m_credit_gnt", 32'(credit_gnt_o), 32'(e_gnt));
      chk("m_credit_id", 32'(credit_id_o), e_gid);
      chk("m_rsv_cnt", 32'(rsv_cnt_o), m_rsv);
      chk("m_credits_pending", 32'(credits_pending_o), m_cred.size());
      chk("m_cred_err", 32'(cred_err_o), m_err);
      if (reset_n) begin
        m_push = rx_valid_i && e_ready;
        if (e_txv && tx_ready_i) void'(m_skid.pop_front());
        if (m_pop) m_skid.push_back(m_data.pop_front());
        if (m_push) m_data.push_back({rx_id_i, rx_payload_i});
        m_rsv = m_rsv + ((m_push && !m_credited) ? 1 : 0) + (e_gnt ? 1 : 0) - (m_pop ? 1 : 0);
        if (m_pop) m_cnt = 0;
        else if (m_stalled && m_cnt < STALL) m_cnt = m_cnt + 1;
        if (rx_valid_i && rx_credit_i && m_res == 0) m_err = 1;
        if (e_gnt) void'(m_cred.pop_front());
        if (e_retry) m_cred.push_back(int'(rx_id_i));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int id, input bit cr, input bit txr);
    rx_valid_i   = v;
    rx_id_i      = ID_W'(id);
    rx_payload_i = PAYLOAD_W'(id * 7 + 3);
    rx_credit_i  = cr;
    tx_ready_i   = txr;
  endtask

  int acc;
  int ntx;

  initial begin
    repeat (2) tick();
    // reset values
    chk("rst_tx_valid", 32'(tx_valid_o), 0);
    chk("rst_rsv", 32'(rsv_cnt_o), 0);
    chk("rst_pending", 32'(credits_pending_o), 0);
    chk("rst_gnt", 32'(credit_gnt_o), 0);
    chk("rst_retry", 32'(rx_retry_o), 0);
    chk("rst_err", 32'(cred_err_o), 0);
    reset_n = 1'b1;

    // Fill: IDs 0..6 back to back, egress blocked
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1, i, 0, 0);
      #2;
      chk("fill_ready", 32'(rx_ready_o), (i < 6) ? 1 : 0);
      if (rx_ready_o) acc++;
      tick();
    end
    chk("fill_accepted", acc, 6);
    chk("fill_rsv", 32'(rsv_cnt_o), 4);
    chk("fill_tx_id", 32'(tx_id_o), 0);

    // ID 6 held stalled: second stalled cycle no retry, third retries
    #2;
    chk("stall2_retry", 32'(rx_retry_o), 0);
    chk("stall2_ready", 32'(rx_ready_o), 0);
    tick();
    #2;
    chk("stall3_retry", 32'(rx_retry_o), 1);
    tick();
    drive(0, 0, 0, 0);
    #2;
    chk("retry_pending", 32'(credits_pending_o), 1);

    // Grant: one egress handshake frees a slot that goes to ID 6
    drive(0, 0, 0, 1);
    #2;
    chk("gnt_strobe", 32'(credit_gnt_o), 1);
    chk("gnt_id", 32'(credit_id_o), 6);
    tick();
    drive(1, 6, 1, 0);
    #2;
    chk("gnt_rsv_hold", 32'(rsv_cnt_o), 4);
    chk("gnt_pending", 32'(credits_pending_o), 0);
    chk("credited_ready", 32'(rx_ready_o), 1);
    tick();
    drive(1, 7, 0, 0);
    #2;
    chk("uncredited_ready", 32'(rx_ready_o), 0);
    tick();
    tick();
    #2;
    chk("id7_retry", 32'(rx_retry_o), 1);
    tick();

    // Saturated counter: every stalled beat retried until the credit FIFO fills
    for (int i = 1; i < 4; i++) begin
      drive(1, i, 0, 0);
      #2;
      chk("sat_retry", 32'(rx_retry_o), 1);
      tick();
    end
    drive(1, 4, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("cfull_retry", 32'(rx_retry_o), 0);
      chk("cfull_ready", 32'(rx_ready_o), 0);
      tick();
    end
    chk("cfull_pending", 32'(credits_pending_o), 4);
    drive(1, 4, 0, 1);
    #2;
    chk("cfull_gnt_id", 32'(credit_id_o), 7);
    tick();

    // Reset mid-flight: data and credits outstanding
    drive(0, 0, 0, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid_o), 0);
    chk("midrst_gnt", 32'(credit_gnt_o), 0);
    chk("midrst_pending", 32'(credits_pending_o), 0);
    chk("midrst_rsv", 32'(rsv_cnt_o), 0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("postrst_tx_valid", 32'(tx_valid_o), 0);
      chk("postrst_gnt", 32'(credit_gnt_o), 0);
      tick();
    end

    // Spurious credit after reset
    drive(1, 5, 1, 1);
    #2;
    chk("spur_ready", 32'(rx_ready_o), 1);
    tick();
    drive(0, 0, 0, 1);
    #2;
    chk("spur_rsv", 32'(rsv_cnt_o), 1);
    chk("spur_err", 32'(cred_err_o), 1);
    repeat (3) tick();
    chk("spur_err_sticky", 32'(cred_err_o), 1);
    reset_n = 1'b0;
    #1;
    chk("spur_err_clear", 32'(cred_err_o), 0);
    tick();
    reset_n = 1'b1;

    // Throughput: 8 beats back to back with egress always ready
    ntx = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(1, i, 0, 1);
      else drive(0, 0, 0, 1);
      #2;
      if (i < 8) chk("tput_ready", 32'(rx_ready_o), 1);
      if (tx_valid_o) ntx++;
      tick();
    end
    chk("tput_count", ntx, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
